// File: rtl/puzzle_regfile.sv
// puzzle_regfile -- register file holding a sliding-puzzle board plus a move-history stack.
//
// Register 0 holds the current board and register 1 the goal board. Each board
// is six 3-bit tiles in the low 18 bits. comp reports, one cycle late, whether
// the two boards match. A separate LIFO stack records the move codes that have
// been played. The register file and the stack are updated independently.
//
// Ports
//   clk              : clock, all state updates on the rising edge
//   rst              : asynchronous, active-high reset
//   chbeg[1:0]       : start-board select, sampled while rst is high
//   src0, src1       : read addresses
//   data0, data1     : read data (combinational)
//   dst, we, data    : write port
//   mv_push, mv_pop  : move-stack push / pop (both high = replace top entry)
//   mv_in[MW-1:0]    : move code to push
//   cnt[6:0]         : stack depth
//   ord              : packed move history, entry 0 in the LSBs, entries >= cnt read as 0
//   full, empty      : stack depth == MOVES / == 0
//   ovf              : sticky, set by a push into a full stack
//   comp             : registered (reg0[17:0] == reg1[17:0])
//
// Build option
//   PUZZLE_REGFILE_BYPASS_EN : when defined, a read of the address being
//   written returns the write data in the same cycle.

module puzzle_regfile #(
    parameter int DW    = 26,
    parameter int AW    = 5,
    parameter int MOVES = 20,
    parameter int MW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          chbeg,
    input  logic [AW-1:0]       src0,
    input  logic [AW-1:0]       src1,
    output logic [DW-1:0]       data0,
    output logic [DW-1:0]       data1,
    input  logic [AW-1:0]       dst,
    input  logic                we,
    input  logic [DW-1:0]       data,
    input  logic                mv_push,
    input  logic                mv_pop,
    input  logic [MW-1:0]       mv_in,
    output logic [6:0]          cnt,
    output logic [MOVES*MW-1:0] ord,
    output logic                full,
    output logic                empty,
    output logic                ovf,
    output logic                comp
);

    localparam int          NREG  = 1 << AW;
    localparam logic [17:0] GOAL  = 18'b000_001_010_011_100_101;
    localparam logic [6:0]  DEPTH = 7'(MOVES);

    function automatic logic [17:0] start_board(input logic [1:0] sel);
        logic [17:0] b;
        case (sel)
            2'b00:   b = 18'b100_010_001_011_101_000;
            2'b01:   b = 18'b100_101_001_011_010_000;
            2'b10:   b = 18'b100_001_101_011_010_000;
            default: b = 18'b000_001_010_011_101_100;
        endcase
        return b;
    endfunction

    // Registers 26/27 only exist when AW >= 5; for smaller files those
    // indices are never visited by the reset loop.
    function automatic logic [DW-1:0] reset_value(input int idx, input logic [1:0] sel);
        logic [DW-1:0] v;
        v = '0;
        case (idx)
            0:       v[17:0] = start_board(sel);
            1:       v[17:0] = GOAL;
            3:       v = DW'(5);
            26, 27:  v = DW'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DW-1:0] regs [NREG];

    // chbeg is a reset-time input, so register 0 is reloaded whenever rst
    // is high (asynchronous load of a selectable start board).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= reset_value(i, chbeg);
            end
        end else if (we) begin
            regs[dst] <= data;
        end
    end

`ifdef PUZZLE_REGFILE_BYPASS_EN
    always_comb begin
        data0 = (we && (src0 == dst)) ? data : regs[src0];
        data1 = (we && (src1 == dst)) ? data : regs[src1];
    end
`else
    always_comb begin
        data0 = regs[src0];
        data1 = regs[src1];
    end
`endif

    // Only the low 18 bits (the six tiles) take part in the comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp <= 1'b0;
        end else begin
            comp <= (regs[0][17:0] == regs[1][17:0]);
        end
    end

    // ------------------------------------------------------------------
    // Move-history stack
    // ------------------------------------------------------------------
    logic [MW-1:0] stk [MOVES];
    logic [6:0]    cnt_q;
    logic          ovf_q;
    logic          do_push;
    logic          do_pop;
    logic          do_repl;

    assign full  = (cnt_q == DEPTH);
    assign empty = (cnt_q == 7'd0);
    assign cnt   = cnt_q;
    assign ovf   = ovf_q;

    // Push+pop on an empty stack degenerates to a plain push; a lone pop on
    // an empty stack is silently dropped.
    always_comb begin
        do_push = mv_push && (!mv_pop || empty);
        do_pop  = mv_pop && !mv_push && !empty;
        do_repl = mv_push && mv_pop && !empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MOVES; i++) begin
                stk[i] <= '0;
            end
            cnt_q <= 7'd0;
            ovf_q <= 1'b0;
        end else if (do_push) begin
            if (full) begin
                ovf_q <= 1'b1;
            end else begin
                for (int i = 0; i < MOVES; i++) begin
                    if (7'(i) == cnt_q) begin
                        stk[i] <= mv_in;
                    end
                end
                cnt_q <= cnt_q + 7'd1;
            end
        end else if (do_pop) begin
            for (int i = 0; i < MOVES; i++) begin
                if (7'(i) == cnt_q - 7'd1) begin
                    stk[i] <= '0;
                end
            end
            cnt_q <= cnt_q - 7'd1;
        end else if (do_repl) begin
            for (int i = 0; i < MOVES; i++) begin
                if (7'(i) == cnt_q - 7'd1) begin
                    stk[i] <= mv_in;
                end
            end
        end
    end

    // Popped entries are already cleared; the mask keeps ord clean regardless.
    always_comb begin
        ord = '0;
        for (int i = 0; i < MOVES; i++) begin
            ord[i*MW +: MW] = (7'(i) < cnt_q) ? stk[i] : '0;
        end
    end

endmodule

// File: tb/tb_puzzle_regfile.sv
module tb_puzzle_regfile;

    localparam int DW    = 26;
    localparam int AW    = 5;
    localparam int MOVES = 20;
    localparam int MW    = 2;
    localparam int NREG  = 32;
    localparam logic [17:0] GOAL = 18'b000_001_010_011_100_101;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [1:0]          chbeg = 2'b01;
    logic [AW-1:0]       src0 = '0, src1 = '0, dst = '0;
    logic [DW-1:0]       data0, data1, data = '0;
    logic                we = 1'b0, mv_push = 1'b0, mv_pop = 1'b0;
    logic [MW-1:0]       mv_in = '0;
    logic [6:0]          cnt;
    logic [MOVES*MW-1:0] ord;
    logic                full, empty, ovf, comp;

    puzzle_regfile #(.DW(DW), .AW(AW), .MOVES(MOVES), .MW(MW)) dut (
        .clk(clk), .rst(rst), .chbeg(chbeg),
        .src0(src0), .src1(src1), .data0(data0), .data1(data1),
        .dst(dst), .we(we), .data(data),
        .mv_push(mv_push), .mv_pop(mv_pop), .mv_in(mv_in),
        .cnt(cnt), .ord(ord), .full(full), .empty(empty), .ovf(ovf), .comp(comp)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Behavioural model: plain array, a queue for the stack, two flags.
    logic [DW-1:0] mreg [NREG];
    int            mstk [$];
    bit            movf;
    bit            mcomp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] board(input logic [1:0] s);
        case (s)
            2'b00:   return 18'b100_010_001_011_101_000;
            2'b01:   return 18'b100_101_001_011_010_000;
            2'b10:   return 18'b100_001_101_011_010_000;
            default: return 18'b000_001_010_011_101_100;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mreg[i] = '0;
        mreg[0]  = DW'(board(chbeg));
        mreg[1]  = DW'(GOAL);
        mreg[3]  = DW'(5);
        mreg[26] = DW'(1);
        mreg[27] = DW'(1);
        mstk.delete();
        movf  = 1'b0;
        mcomp = 1'b0;
    endtask

    task automatic model_step();
        bit nc;
        nc = (mreg[0][17:0] == mreg[1][17:0]);
        if (we) mreg[dst] = data;
        if (mv_push && mv_pop && mstk.size() > 0) begin
            mstk[mstk.size()-1] = int'(mv_in);
        end else if (mv_push) begin
            if (mstk.size() < MOVES) mstk.push_back(int'(mv_in));
            else movf = 1'b1;
        end else if (mv_pop && mstk.size() > 0) begin
            void'(mstk.pop_back());
        end
        mcomp = nc;
    endtask

    function automatic logic [MOVES*MW-1:0] exp_ord();
        logic [MOVES*MW-1:0] o;
        o = '0;
        for (int i = 0; i < mstk.size(); i++) o[i*MW +: MW] = MW'(mstk[i]);
        return o;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef PUZZLE_REGFILE_BYPASS_EN
        if (we && a == dst) return data;
`endif
        return mreg[a];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data0", 64'(data0), 64'(exp_rd(src0)));
            chk("data1", 64'(data1), 64'(exp_rd(src1)));
            chk("cnt",   64'(cnt),   64'(mstk.size()));
            chk("ord",   64'(ord),   64'(exp_ord()));
            chk("full",  64'(full),  64'(mstk.size() == MOVES));
            chk("empty", 64'(empty), 64'(mstk.size() == 0));
            chk("ovf",   64'(ovf),   64'(movf));
            chk("comp",  64'(comp),  64'(mcomp));
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; mv_push = 1'b0; mv_pop = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] s);
        chbeg = s;
        rst   = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        // Reset-value pins for two start boards.
        do_reset(2'b11);
        src0 = 0; #1;
        chk("rst_board11", 64'(data0), 64'({8'b0, 18'b000_001_010_011_101_100}));
        do_reset(2'b01);
        chk_en = 1'b1;
        src0 = 0; src1 = 1; #1;
        chk("rst_board01", 64'(data0), 64'({8'b0, 18'b100_101_001_011_010_000}));
        chk("rst_goal",    64'(data1), 64'({8'b0, 18'b000_001_010_011_100_101}));
        chk("rst_comp",    64'(comp),  64'(0));
        chk("rst_empty",   64'(empty), 64'(1));
        src0 = 3; src1 = 26; #1;
        chk("rst_reg3",    64'(data0), 64'(5));
        chk("rst_reg26",   64'(data1), 64'(1));

        // Push 1,2,3 then pop.
        mv_push = 1; mv_in = 1; tick();
        mv_in = 2; tick();
        mv_in = 3; tick();
        idle();
        chk("push3_cnt", 64'(cnt), 64'(3));
        chk("push3_ord", 64'(ord[5:0]), 64'(6'b11_10_01));
        mv_pop = 1; tick(); idle();
        chk("pop_cnt", 64'(cnt), 64'(2));
        chk("pop_ord", 64'(ord[5:0]), 64'(6'b00_10_01));

        // Replace at cnt=2, then empty the stack, then push+pop at cnt=0.
        mv_push = 1; mv_pop = 1; mv_in = 3; tick(); idle();
        chk("repl_cnt", 64'(cnt), 64'(2));
        chk("repl_ord", 64'(ord[5:0]), 64'(6'b00_11_01));
        mv_pop = 1; tick(); tick(); tick(); idle();
        chk("pop_empty_ovf", 64'(ovf), 64'(0));
        mv_push = 1; mv_pop = 1; mv_in = 3; tick(); idle();
        chk("pp0_cnt", 64'(cnt), 64'(1));
        chk("pp0_ord", 64'(ord[1:0]), 64'(2'b11));
        mv_pop = 1; tick(); idle();

        // Write-to-read forwarding on reg 4 (reset value 0).
        we = 1; dst = 4; src0 = 4; data = 26'h155; #1;
`ifdef PUZZLE_REGFILE_BYPASS_EN
        chk("bypass_same_cycle", 64'(data0), 64'(26'h155));
`else
        chk("bypass_same_cycle", 64'(data0), 64'(0));
`endif
        tick(); idle(); #1;
        chk("after_write", 64'(data0), 64'(26'h155));

        // comp follows reg0 == reg1 with one cycle of latency.
        we = 1; dst = 0; data = DW'(GOAL); tick(); idle();
        chk("comp_lag", 64'(comp), 64'(0));
        tick();
        chk("comp_set", 64'(comp), 64'(1));
        we = 1; dst = 0; data = '0; tick(); idle();
        chk("comp_hold", 64'(comp), 64'(1));
        tick();
        chk("comp_clr", 64'(comp), 64'(0));
        we = 1; dst = 0; data = {8'hA5, GOAL}; tick(); idle(); tick();
        chk("comp_upper_ignored", 64'(comp), 64'(1));

        // Register write and stack op together, then a full read sweep.
        we = 1; dst = 9; data = 26'h2AB_CDEF; mv_push = 1; mv_in = 2; tick(); idle();
        for (int i = 5; i < 13; i++) begin
            we = 1; dst = AW'(i); data = DW'(i * 32'h0012_3457); tick();
        end
        idle();
        for (int i = 0; i < NREG; i++) begin
            src0 = AW'(i); src1 = AW'(NREG - 1 - i); tick();
        end
        mv_pop = 1; tick(); idle();

        // Overflow: 21 pushes into a 20-deep stack, then one pop.
        for (int i = 0; i < 21; i++) begin
            mv_push = 1; mv_in = MW'(i % 3 + 1); tick();
        end
        idle();
        chk("ovf_cnt",   64'(cnt), 64'(20));
        chk("ovf_full",  64'(full), 64'(1));
        chk("ovf_flag",  64'(ovf), 64'(1));
        chk("ovf_e19",   64'(ord[39:38]), 64'(2'b10));
        mv_pop = 1; tick(); idle();
        chk("ovf_pop_full", 64'(full), 64'(0));
        chk("ovf_sticky",   64'(ovf), 64'(1));

        // Reset asserted mid-operation.
        we = 1; dst = 3; data = '1; mv_push = 1; mv_in = 1;
        #2;
        do_reset(2'b10);
        idle();
        src0 = 0; src1 = 27; #1;
        chk("mid_board10", 64'(data0), 64'({8'b0, 18'b100_001_101_011_010_000}));
        chk("mid_reg27",   64'(data1), 64'(1));
        src0 = 3; #1;
        chk("mid_reg3",    64'(data0), 64'(5));
        chk("mid_cnt",     64'(cnt), 64'(0));
        chk("mid_ovf",     64'(ovf), 64'(0));
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/puzzle_regfile.md
PUZZLE_REGFILE -- requirements
Module: puzzle_regfile

Interface
REQ-001 SHALL provide parameter DW, default 26, register data width; legal range 18..64.
REQ-002 SHALL provide parameter AW, default 5, address width; register count 2^AW, legal range 3..6.
REQ-003 SHALL provide parameter MOVES, default 20, move-history stack depth; legal range 1..64.
REQ-004 SHALL provide parameter MW, default 2, width of one move code.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port chbeg, input, 2: start-board select, sampled while rst is high.
REQ-008 SHALL have ports src0, src1, input, AW each: read addresses.
REQ-009 SHALL have ports data0, data1, output, DW each: read data.
REQ-010 SHALL have ports dst (input, AW), we (input, 1) and data (input, DW): write port.
REQ-011 SHALL have ports mv_push (input, 1), mv_pop (input, 1) and mv_in (input, MW): move-stack controls.
REQ-012 SHALL have port cnt, output, 7: stack depth, zero-extended.
REQ-013 SHALL have port ord, output, MOVES*MW: packed move history; entry 0 in LSBs.
REQ-014 SHALL have ports full, empty and ovf, output, 1 each: stack full, stack empty, sticky overflow.
REQ-015 SHALL have port comp, output, 1: board (reg 0) equals goal (reg 1), registered.

Function
REQ-016 SHALL write data into register dst on a rising clk edge when we=1; when we=0 all registers hold.
REQ-017 SHALL drive data0/data1 combinationally from registers src0/src1.
REQ-018 SHALL push mv_in into entry cnt and increment cnt on mv_push=1, mv_pop=0, cnt<MOVES.
REQ-019 SHALL, on a push while cnt==MOVES, drop the push, hold the stack and cnt, and set ovf (sticky until rst).
REQ-020 SHALL, on mv_pop=1 with mv_push=0 and cnt>0, clear entry cnt-1 to zero and decrement cnt; a pop at cnt==0 is ignored with no flag.
REQ-021 SHALL, on simultaneous mv_push and mv_pop with cnt>0, replace entry cnt-1 with mv_in and hold cnt; at cnt==0, treat it as a push.
REQ-022 SHALL force ord entries at index >= cnt to zero at all times.
REQ-023 SHALL drive full=(cnt==MOVES) and empty=(cnt==0) combinationally.
REQ-024 SHALL set comp one cycle after register 0 equals register 1 over the low 18 bits, and clear it one cycle after they differ.
REQ-025 SHALL make register-file writes and stack operations in the same cycle fully independent.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, load register 0 with the zero-extended start board selected by chbeg:
- 00 = 100_010_001_011_101_000
- 01 = 100_101_001_011_010_000
- 10 = 100_001_101_011_010_000
- 11 = 000_001_010_011_101_100
REQ-027 SHALL, while rst=1, set register 1 = 000_001_010_011_100_101 (goal), register 3 = 5, registers 26 and 27 = 1 where they exist, and all other registers = 0.
REQ-028 SHALL, while rst=1, clear every stack entry, cnt and ovf, and hold comp=0; therefore empty=1 and full=0.
REQ-029 SHALL abandon any write or stack operation in flight when rst asserts mid-operation; the first update after rst deasserts is on the next rising clk edge.

Configuration
REQ-030 SHALL, when macro PUZZLE_REGFILE_BYPASS_EN is defined, return data on data0/data1 when we=1 and src equals dst (write-to-read forwarding).
REQ-031 SHALL, when PUZZLE_REGFILE_BYPASS_EN is not defined, always return the stored register value; a read of dst returns the new value only from the cycle after the write.

Verification
REQ-032 SHALL cover reset with chbeg=01 -> data0 for src0=0 reads 0x0000000|100_101_001_011_010_000, src0=1 reads the goal value, comp=0, empty=1.
REQ-033 SHALL cover push codes 1,2,3 over three cycles -> cnt=3 and ord[5:0]=11_10_01; then a pop -> cnt=2 and ord[5:0]=00_10_01.
REQ-034 SHALL cover 21 pushes at MOVES=20 -> cnt=20, full=1, ovf=1, entry 19 unchanged; then a pop -> full=0 with ovf still 1.
REQ-035 SHALL cover push+pop in the same cycle with cnt=2 and mv_in=3 -> cnt=2 and entry 1 = 3; the same at cnt=0 -> cnt=1 and entry 0 = 3.
REQ-036 SHALL cover writing the goal value into reg 0 -> comp=1 one cycle later; writing 0 into reg 0 -> comp=0 one cycle later.
REQ-037 SHALL cover we=1, dst=src0=4, data=0x155 -> data0=0x155 in the same cycle with PUZZLE_REGFILE_BYPASS_EN and the old value 0 without it; rst pulsed mid-sequence -> all state returns to reset values.
